video_ring_overlay: RTL and testbench
=====================================

VIDEO_RING_OVERLAY -- requirements
Module: video_ring_overlay

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1920: active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 1080: active lines per frame.
REQ-003 SHALL have parameter CNT_W, default 12: width of the pixel and line counters.
REQ-004 SHALL have parameter N_RINGS, default 2, range 1..4: number of concentric rings.
REQ-005 SHALL have parameter R0, default 200: inner radius of ring 0, in pixels.
REQ-006 SHALL have parameter R_STEP, default 100: radius increment per ring.
REQ-007 SHALL have parameter THICK, default 40: ring thickness in pixels.
REQ-008 SHALL have parameter RING_RGB, default 24'hFF5A43: base ring colour.
REQ-009 SHALL have parameter BG_RGB, default 24'h000000: solid background for mode 2.
REQ-010 SHALL have port clk_i, in, 1: single clock.
REQ-011 SHALL have port rst_ni, in, 1: asynchronous active-low reset.
REQ-012 SHALL have port cen_i, in, 1: video clock enable.
REQ-013 SHALL have port mode_i, in, 2: display mode request.
REQ-014 SHALL have port vid_rgb_i, in, 24: {R,G,B} input pixel.
REQ-015 SHALL have port vh_blank_i, in, 2: {Vblank,Hblank}.
REQ-016 SHALL have port dvh_sync_i, in, 3: {D,V,H} sync.
REQ-017 SHALL have port vid_rgb_o, out, 24: processed pixel.
REQ-018 SHALL have port vh_blank_o, out, 2: delayed blanking.
REQ-019 SHALL have port dvh_sync_o, out, 3: delayed sync.
REQ-020 SHALL have port frame_cnt_o, out, 16: completed-frame count.

Function
REQ-021 SHALL advance every register only on clk_i edges with cen_i=1; otherwise all state holds.
REQ-022 SHALL detect blank edges against registered copies of vh_blank_i.
REQ-023 SHALL clear h_cnt on Hblank fall and increment it on each enabled active pixel, saturating at H_ACTIVE-1.
REQ-024 SHALL clear v_cnt on Vblank fall and increment it on each Hblank rise while Vblank=0, saturating at V_ACTIVE-1.
REQ-025 SHALL increment frame_cnt_o on each Vblank rise, wrapping 16'hFFFF->0.
REQ-026 SHALL sample mode_i into active_mode only on Vblank rise, so mode changes take effect from the next frame.
REQ-027 Pipeline stage 1 SHALL register signed dx=h_cnt-H_ACTIVE/2 and dy=v_cnt-V_ACTIVE/2, each CNT_W+1 bits.
REQ-028 Stage 2 SHALL register unsigned d2=dx*dx+dy*dy, 2*CNT_W+2 bits, without overflow.
REQ-029 Stage 3 SHALL evaluate ring k hit as (rk)^2 <= d2 < (rk+THICK)^2, where rk=R0+k*R_STEP+off, and SHALL register the output pixel.
REQ-030 When several rings hit, the lowest-index ring SHALL win.
REQ-031 Ring k colour SHALL be each RING_RGB channel logically shifted right by k.
REQ-032 Mode 0 SHALL pass vid_rgb_i through unmodified.
REQ-033 Mode 1 SHALL draw rings over vid_rgb_i.
REQ-034 Mode 2 SHALL draw rings over BG_RGB.
REQ-035 Mode 3 SHALL output the gradient {h_cnt[7:0], v_cnt[7:0], frame_cnt_o[7:0]}, with no rings.
REQ-036 vid_rgb_o, vh_blank_o and dvh_sync_o SHALL share a latency of exactly 3 enabled cycles.
REQ-037 vid_rgb_o SHALL be 24'h0 whenever the delayed blanking has either bit set, in all modes including mode 0.
REQ-038 When Hblank fall and Vblank fall coincide, both counters SHALL clear in that cycle.

Reset
REQ-039 On rst_ni=0, all outputs, counters and pipeline registers SHALL clear to 0, active_mode SHALL clear to 0, and edge registers SHALL clear to 1 (blank).
REQ-040 Reset assertion mid-line SHALL take effect immediately; after release, the first Hblank fall SHALL restart h_cnt at 0.

Configuration
REQ-041 With VIDEO_RING_PULSE_EN defined, off SHALL equal a triangle wave: frame_cnt_o[6] ? ~frame_cnt_o[5:0] : frame_cnt_o[5:0], range 0..63.
REQ-042 Without VIDEO_RING_PULSE_EN, off SHALL be constant 0 and the triangle logic SHALL be absent.

Verification
REQ-043 Mode 0, cen_i=1, pixel 24'h123456 active -> vid_rgb_o=24'h123456 exactly 3 cycles later; sync and blank aligned.
REQ-044 Mode 2, pixel (1160,540) -> d2=40000 -> 24'hFF5A43; pixel (1200,540) -> 24'h000000; pixel (1260,540) -> 24'h7F2D21 (ring 1).
REQ-045 cen_i toggling 1/0 -> output identical to cen_i=1 run with each value held for 2 clocks.
REQ-046 mode_i changed 0->3 mid-frame -> mode 0 persists until Vblank rise, then gradient appears.
REQ-047 frame_cnt_o preloaded to 16'hFFFF via 65535 frames or force, then Vblank rise -> 0; with PULSE_EN at frame 64, off=63.
REQ-048 rst_ni pulsed low mid-line -> all outputs 0 asynchronously; next line counts from h_cnt=0.

Source files
------------

// File: rtl/video_ring_overlay.sv
// video_ring_overlay: derives pixel/line position from the blanking edges,
// computes squared distance from the screen centre in a three-stage pipeline
// and overlays up to four concentric rings (or a test gradient) on the video.
// Optional feature: define VIDEO_RING_PULSE_EN to make every ring radius
// pulse with a 0..63 pixel triangle wave driven by the frame counter.
module video_ring_overlay #(
    parameter int          H_ACTIVE = 1920,
    parameter int          V_ACTIVE = 1080,
    parameter int          CNT_W    = 12,
    parameter int          N_RINGS  = 2,
    parameter int          R0       = 200,
    parameter int          R_STEP   = 100,
    parameter int          THICK    = 40,
    parameter logic [23:0] RING_RGB = 24'hFF5A43,
    parameter logic [23:0] BG_RGB   = 24'h000000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cen_i,
    input  logic [1:0]  mode_i,
    input  logic [23:0] vid_rgb_i,
    input  logic [1:0]  vh_blank_i,
    input  logic [2:0]  dvh_sync_i,
    output logic [23:0] vid_rgb_o,
    output logic [1:0]  vh_blank_o,
    output logic [2:0]  dvh_sync_o,
    output logic [15:0] frame_cnt_o
);
    localparam int               D2_W   = 2 * CNT_W + 2;
    localparam logic [CNT_W:0]   DX_OFS = (CNT_W + 1)'(H_ACTIVE / 2);
    localparam logic [CNT_W:0]   DY_OFS = (CNT_W + 1)'(V_ACTIVE / 2);
    localparam logic [CNT_W-1:0] H_MAX  = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_MAX  = CNT_W'(V_ACTIVE - 1);

    typedef enum logic [1:0] {
        MODE_PASS     = 2'd0,
        MODE_RING_VID = 2'd1,
        MODE_RING_BG  = 2'd2,
        MODE_GRAD     = 2'd3
    } mode_e;

    // Edge detection, position counters and frame-level state
    logic             vb_in, hb_in, vb_q, hb_q;
    logic             h_fall, h_rise, v_fall, v_rise;
    logic [CNT_W-1:0] h_cnt, v_cnt, h_nxt, v_nxt;
    mode_e            active_mode;
    logic [5:0]       off;

    // Pipeline registers
    logic signed [CNT_W:0] s1_dx, s1_dy;
    logic [23:0]           s1_rgb, s1_grad, s2_rgb, s2_grad;
    logic [1:0]            s1_blank, s2_blank;
    logic [2:0]            s1_sync, s2_sync;
    mode_e                 s1_mode, s2_mode;
    logic [D2_W-1:0]       s2_d2;
    logic signed [D2_W-1:0] dx_ext, dy_ext;

    // Ring evaluation
    logic        ring_hit;
    logic [23:0] ring_rgb, pix_nxt;

    assign vb_in  = vh_blank_i[1];
    assign hb_in  = vh_blank_i[0];
    assign h_fall = hb_q & ~hb_in;
    assign h_rise = ~hb_q & hb_in;
    assign v_fall = vb_q & ~vb_in;
    assign v_rise = ~vb_q & vb_in;

`ifdef VIDEO_RING_PULSE_EN
    assign off = frame_cnt_o[6] ? ~frame_cnt_o[5:0] : frame_cnt_o[5:0];
`else
    assign off = 6'd0;
`endif

    // Next pixel/line position: the cleared or incremented value belongs to
    // the pixel presented this cycle, so stage 1 sees the pixel's own column.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
        h_nxt = h_cnt;
        v_nxt = v_cnt;
        if (h_fall)
            h_nxt = '0;
        else if (vh_blank_i == 2'b00 && h_cnt != H_MAX)
            h_nxt = h_cnt + 1'b1;
        if (v_fall)
            v_nxt = '0;
        else if (h_rise && !vb_in && v_cnt != V_MAX)
            v_nxt = v_cnt + 1'b1;
    end

    // Edge registers, counters, frame count and per-frame mode latch
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vb_q        <= 1'b1;
            hb_q        <= 1'b1;
            h_cnt       <= '0;
            v_cnt       <= '0;
            frame_cnt_o <= '0;
            active_mode <= MODE_PASS;
        end else if (cen_i) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            vb_q  <= vb_in;
            hb_q  <= hb_in;
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
            if (v_rise) begin
                frame_cnt_o <= frame_cnt_o + 16'd1;
                active_mode <= mode_e'(mode_i);
            end
        end
    end

    // Stage 1: signed offsets from screen centre plus aligned video
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_dx    <= '0;
            s1_dy    <= '0;
            s1_rgb   <= '0;
            s1_grad  <= '0;
            s1_blank <= '0;
            s1_sync  <= '0;
            s1_mode  <= MODE_PASS;
        end else if (cen_i) begin
            s1_dx    <= $signed({1'b0, h_nxt}) - $signed(DX_OFS);
            s1_dy    <= $signed({1'b0, v_nxt}) - $signed(DY_OFS);
            s1_rgb   <= vid_rgb_i;
            s1_grad  <= {h_nxt[7:0], v_nxt[7:0], frame_cnt_o[7:0]};
            s1_blank <= vh_blank_i;
            s1_sync  <= dvh_sync_i;
            s1_mode  <= active_mode;
        end
    end

    // Sign-extend before squaring so the products cannot overflow
    assign dx_ext = D2_W'(s1_dx);
    assign dy_ext = D2_W'(s1_dy);

    // Stage 2: squared distance
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_d2    <= '0;
            s2_rgb   <= '0;
            s2_grad  <= '0;
            s2_blank <= '0;
            s2_sync  <= '0;
            s2_mode  <= MODE_PASS;
        end else if (cen_i) begin
            s2_d2    <= dx_ext * dx_ext + dy_ext * dy_ext;
            s2_rgb   <= s1_rgb;
            s2_grad  <= s1_grad;
            s2_blank <= s1_blank;
            s2_sync  <= s1_sync;
            s2_mode  <= s1_mode;
        end
    end

    // Ring hit test; scanning from the outermost ring lets ring 0 win ties
    always_comb begin
        logic [D2_W-1:0] rk, r_lo, r_hi;
        ring_hit = 1'b0;
        ring_rgb = '0;
        rk       = '0;
        r_lo     = '0;
        r_hi     = '0;
        for (int k = N_RINGS - 1; k >= 0; k--) begin
            rk   = D2_W'(R0 + k * R_STEP) + D2_W'(off);
            r_lo = rk * rk;
            r_hi = (rk + D2_W'(THICK)) * (rk + D2_W'(THICK));
            if (s2_d2 >= r_lo && s2_d2 < r_hi) begin
                ring_hit = 1'b1;
                ring_rgb = {RING_RGB[23:16] >> k, RING_RGB[15:8] >> k, RING_RGB[7:0] >> k};
            end
        end
    end

    // Output pixel selection by mode, forced black during blanking
    always_comb begin
        pix_nxt = s2_rgb;
        case (s2_mode)
            MODE_PASS:     pix_nxt = s2_rgb;
            MODE_RING_VID: pix_nxt = ring_hit ? ring_rgb : s2_rgb;
            MODE_RING_BG:  pix_nxt = ring_hit ? ring_rgb : BG_RGB;
            MODE_GRAD:     pix_nxt = s2_grad;
            default:       pix_nxt = s2_rgb;
        endcase
        if (s2_blank != 2'b00)
            pix_nxt = '0;
    end

    // Stage 3: registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vid_rgb_o  <= '0;
            vh_blank_o <= '0;
            dvh_sync_o <= '0;
        end else if (cen_i) begin
            vid_rgb_o  <= pix_nxt;
            vh_blank_o <= s2_blank;
            dvh_sync_o <= s2_sync;
        end
    end

endmodule

// File: tb/tb_video_ring_overlay.sv
// Testbench for video_ring_overlay: a frame generator that knows each
// pixel's coordinates, a reference model computing expected pixels from the
// ring geometry, random clock-enable gaps, and a table of ring boundary points.
module tb_video_ring_overlay;
    localparam int          H_ACTIVE = 1920;
    localparam int          V_ACTIVE = 1080;
    localparam int          N_RINGS  = 2;
    localparam int          R0       = 200;
    localparam int          R_STEP   = 100;
    localparam int          THICK    = 40;
    localparam logic [23:0] RING_C   = 24'hFF5A43;
    localparam logic [23:0] BG_C     = 24'h000000;
    localparam int          LONG_LEN = 1320;
    localparam int          CAP_LINE = 540;

    logic        clk_i = 1'b0;
    logic        rst_ni, cen_i;
    logic [1:0]  mode_i, vh_blank_i, vh_blank_o;
    logic [23:0] vid_rgb_i, vid_rgb_o;
    logic [2:0]  dvh_sync_i, dvh_sync_o;
    logic [15:0] frame_cnt_o;

    always #5 clk_i = ~clk_i;

    video_ring_overlay dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .cen_i       (cen_i),
        .mode_i      (mode_i),
        .vid_rgb_i   (vid_rgb_i),
        .vh_blank_i  (vh_blank_i),
        .dvh_sync_i  (dvh_sync_i),
        .vid_rgb_o   (vid_rgb_o),
        .vh_blank_o  (vh_blank_o),
        .dvh_sync_o  (dvh_sync_o),
        .frame_cnt_o (frame_cnt_o)
    );

    typedef struct {
        logic [23:0] rgb;
        logic [1:0]  blank;
        logic [2:0]  sync;
        int          cap_mode;
        int          cap_x;
    } exp_t;

    typedef struct {
        int          mode;
        int          x;
        logic [23:0] exp_rgb;
    } vec_t;

    exp_t        pipe_q[$];
    exp_t        cur_exp;
    exp_t        zero_exp;
    logic [15:0] model_fcnt;
    int          frame_mode;
    int          cen_pct;
    int          n_vec = 0;
    int          n_err = 0;
    logic [23:0] cap[4][LONG_LEN];
    vec_t        tbl[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Index of the lowest ring containing (x,y), or -1
    function automatic int ring_index(input int x, input int y, input logic [15:0] fcnt);
        int dx = x - H_ACTIVE / 2;
        int dy = y - V_ACTIVE / 2;
        int d2 = dx * dx + dy * dy;
        int off = 0;
        int r;
`ifdef VIDEO_RING_PULSE_EN
        off = fcnt[6] ? 63 - int'(fcnt[5:0]) : int'(fcnt[5:0]);
`endif
        for (int k = 0; k < N_RINGS; k++) begin
            r = R0 + k * R_STEP + off;
            if (d2 >= r * r && d2 < (r + THICK) * (r + THICK))
                return k;
        end
        return -1;
    endfunction

    function automatic logic [23:0] model_pixel(input logic [1:0] blank, input logic [23:0] vid,
                                                input int col, input int line, input int mode,
                                                input logic [15:0] fcnt);
        int          x = (col > H_ACTIVE - 1) ? H_ACTIVE - 1 : col;
        int          y = (line > V_ACTIVE - 1) ? V_ACTIVE - 1 : line;
        int          k;
        logic [23:0] rc = RING_C;
        logic [7:0]  r8, g8, b8;
        if (blank != 2'b00) return 24'h0;
        if (mode == 3) return {x[7:0], y[7:0], fcnt[7:0]};
        if (mode == 0) return vid;
        k = ring_index(x, y, fcnt);
        if (k < 0) return (mode == 1) ? vid : BG_C;
        r8 = rc[23:16] >> k;
        g8 = rc[15:8] >> k;
        b8 = rc[7:0] >> k;
        return {r8, g8, b8};
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_rgb"},   vid_rgb_o,   cur_exp.rgb);
        check({tag, "_blank"}, vh_blank_o,  cur_exp.blank);
        check({tag, "_sync"},  dvh_sync_o,  cur_exp.sync);
        check({tag, "_frame"}, frame_cnt_o, model_fcnt);
    endtask

    // Deliver one pixel on an enabled edge, with random disabled edges
    // carrying garbage in between; outputs are checked after every edge.
    task automatic drive(input logic [1:0] blank, input logic [23:0] vid, input int col,
                         input int line, input bit rise, input int nm);
        bit          en;
        exp_t        e;
        logic [2:0]  sync;
        sync = 3'($urandom);
        do begin
            en    = ($urandom_range(0, 99) < cen_pct);
            cen_i = en;
            if (en) begin
                vh_blank_i = blank;
                vid_rgb_i  = vid;
                dvh_sync_i = sync;
                mode_i     = rise ? nm[1:0] : 2'($urandom);
            end else begin
                vh_blank_i = 2'($urandom);
                vid_rgb_i  = 24'($urandom);
                dvh_sync_i = 3'($urandom);
                mode_i     = 2'($urandom);
            end
            @(posedge clk_i);
            #1;
            if (en) begin
                e.rgb      = model_pixel(blank, vid, col, line, frame_mode, model_fcnt);
                e.blank    = blank;
                e.sync     = sync;
                e.cap_mode = (blank == 2'b00 && line == CAP_LINE && col < LONG_LEN &&
                              (frame_mode == 1 || frame_mode == 2)) ? frame_mode : -1;
                e.cap_x    = col;
                pipe_q.push_back(e);
                if (rise) begin
                    model_fcnt = model_fcnt + 16'd1;
                    frame_mode = nm;
                end
                cur_exp = pipe_q.pop_front();
                if (cur_exp.cap_mode >= 0)
                    cap[cur_exp.cap_mode][cur_exp.cap_x] = vid_rgb_o;
            end
            check_outputs("pipe");
        end while (!en);
    endtask

    // One frame: vertical blanking, n_lines lines, then a Vblank rise that
    // requests next_mode. Lines 539..541 are long when long_mid is set.
    task automatic frame(input int n_lines, input int short_len, input int first_len,
                         input bit long_mid, input bit coincide, input int next_mode);
        repeat (3) drive(2'b11, 24'($urandom), 0, 0, 1'b0, 0);
        for (int y = 0; y < n_lines; y++) begin
            int len = (y == 0) ? first_len :
                      (long_mid && y >= 539 && y <= 541) ? LONG_LEN : short_len;
            if (!(coincide && y == 0))
                repeat (2) drive(2'b01, 24'($urandom), 0, y, 1'b0, 0);
            for (int x = 0; x < len; x++)
                drive(2'b00, (len == LONG_LEN) ? 24'h123456 : 24'($urandom), x, y, 1'b0, 0);
        end
        drive(2'b11, 24'($urandom), 0, 0, 1'b1, next_mode);
    endtask

    task automatic reset_model();
        pipe_q.delete();
        pipe_q.push_back(zero_exp);
        pipe_q.push_back(zero_exp);
        cur_exp    = zero_exp;
        model_fcnt = 16'd0;
        frame_mode = 0;
    endtask

    initial begin
        zero_exp = '{rgb: 24'h0, blank: 2'b00, sync: 3'b000, cap_mode: -1, cap_x: 0};
        tbl[0]  = '{2, 1160, 24'hFF5A43};
        tbl[1]  = '{2, 1200, 24'h000000};
        tbl[2]  = '{2, 1260, 24'h7F2D21};
        tbl[3]  = '{2,  960, 24'h000000};
        tbl[4]  = '{2, 1199, 24'hFF5A43};
        tbl[5]  = '{2, 1259, 24'h000000};
        tbl[6]  = '{2, 1299, 24'h7F2D21};
        tbl[7]  = '{2, 1300, 24'h000000};
        tbl[8]  = '{2,  760, 24'hFF5A43};
        tbl[9]  = '{1, 1160, 24'hFF5A43};
        tbl[10] = '{1, 1100, 24'h123456};
        tbl[11] = '{1, 1280, 24'h7F2D21};
        tbl[12] = '{1, 1310, 24'h123456};

        rst_ni     = 1'b0;
        cen_i      = 1'b0;
        mode_i     = 2'd0;
        vid_rgb_i  = 24'h0;
        vh_blank_i = 2'b11;
        dvh_sync_i = 3'b000;
        cen_pct    = 100;
        reset_model();

        repeat (2) @(posedge clk_i);
        #1;
        check_outputs("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Mode 0 pass-through; mode_i wanders mid-frame, 3 taken at Vblank rise
        frame(6, 8, 8, 1'b0, 1'b0, 3);
        // Gradient, coincident Hblank/Vblank fall, both counters saturating
        frame(1082, 1, 1925, 1'b0, 1'b1, 2);
        // Rings over background, then over video, reaching the centre line
        frame(543, 2, 2, 1'b1, 1'b0, 1);
        frame(543, 2, 2, 1'b1, 1'b0, 0);

`ifndef VIDEO_RING_PULSE_EN
        for (int i = 0; i < 13; i++)
            check($sformatf("ring_table_m%0d_x%0d", tbl[i].mode, tbl[i].x),
                  cap[tbl[i].mode][tbl[i].x], tbl[i].exp_rgb);
`endif

        // Random modes and clock-enable gaps
        cen_pct = 60;
        repeat (4)
            frame($urandom_range(3, 12), $urandom_range(1, 6), $urandom_range(1, 6),
                  1'b0, 1'($urandom), $urandom_range(0, 3));
        frame(543, 2, 2, 1'b1, 1'b0, $urandom_range(0, 3));
        frame(4, 5, 5, 1'b0, 1'b0, 3);
        frame(4, 5, 5, 1'b0, 1'b0, 0);

        // Frame counter wrap from 16'hFFFF
        cen_pct = 100;
        force dut.frame_cnt_o = 16'hFFFF;
        #1;
        release dut.frame_cnt_o;
        model_fcnt = 16'hFFFF;
        frame(3, 4, 4, 1'b0, 1'b0, 3);
        check("frame_wrap", frame_cnt_o, 16'h0000);
        frame(4, 300, 300, 1'b0, 1'b0, 0);

        // Asynchronous reset in the middle of an active line
        repeat (2) drive(2'b11, 24'($urandom), 0, 0, 1'b0, 0);
        repeat (2) drive(2'b01, 24'($urandom), 0, 0, 1'b0, 0);
        for (int x = 0; x < 5; x++) drive(2'b00, 24'h123456, x, 0, 1'b0, 0);
        rst_ni = 1'b0;
        #1;
        reset_model();
        check_outputs("rst_async");
        repeat (2) begin
            @(posedge clk_i);
            #1;
            check_outputs("rst_hold");
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        frame(3, 4, 4, 1'b0, 1'b0, 3);
        frame(3, 20, 20, 1'b0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
